// File: rtl/trigger_capture.sv
// trigger_capture
//   Circular capture buffer for an 8-bit sample stream. Keeps PRETRIG samples
//   ahead of a level/slope (or forced) trigger and stops once DEPTH samples
//   make up the record. The record is then presented, trigger-aligned, to the
//   display reader.
//
// Ports
//   clk, rst              system clock; synchronous active-high reset
//   sample_in/valid       incoming sample stream
//   arm                   start a capture (accepted in IDLE/DONE)
//   force_trig            trigger immediately while waiting for a trigger
//   trig_level/slope      threshold and direction (0 rising, 1 falling)
//   rd_addr -> rd_data    record index 0 = oldest, PRETRIG = trigger sample;
//                         rd_data is registered (1-cycle latency)
//   busy, done            capture in progress / record ready
//
// state     | meaning
// ----------+-----------------------------------------------------
// IDLE      | after reset, writes blocked, waiting for arm
// PREFILL   | collecting the first PRETRIG samples
// WAIT_TRIG | rolling buffer, evaluating the trigger on each sample
// POST      | filling the post-trigger part of the record
// DONE      | record frozen and readable, waiting for re-arm
module trigger_capture #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 8,
   parameter int PRETRIG = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   input  logic              arm,
   input  logic              force_trig,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              trig_slope,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = ADDR_W + 1;

   localparam logic [CNT_W-1:0]  PREFILL_LAST = CNT_W'(PRETRIG - 1);
   localparam logic [CNT_W-1:0]  POST_LAST    = CNT_W'(DEPTH - PRETRIG - 1);
   localparam logic [ADDR_W-1:0] PRE_OFFSET   = ADDR_W'(PRETRIG);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_PREFILL   = 3'd1,
      S_WAIT_TRIG = 3'd2,
      S_POST      = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_next_state;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_start_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [DATA_W-1:0] r_prev;
   logic              r_prev_ok;
   logic              r_force_pend;
   logic [DATA_W-1:0] r_rd_data;

   logic              w_active;
   logic              w_wr_en;
   logic              w_arm_ok;
   logic              w_level_hit;
   logic              w_trig;
   logic              w_prefill_last;
   logic              w_post_last;
   logic [ADDR_W-1:0] w_rd_index;

   assign w_active = (r_state == S_PREFILL) || (r_state == S_WAIT_TRIG) ||
                     (r_state == S_POST);
   assign w_wr_en  = w_active && sample_valid;
   assign w_arm_ok = arm && ((r_state == S_IDLE) || (r_state == S_DONE));

   assign w_level_hit = trig_slope ?
                        ((r_prev > trig_level) && (sample_in <= trig_level)) :
                        ((r_prev < trig_level) && (sample_in >= trig_level));

   // A force request seen on a cycle without a valid sample is remembered so
   // the next valid sample becomes the trigger sample.
   assign w_trig = (r_state == S_WAIT_TRIG) && sample_valid &&
                   ((r_prev_ok && w_level_hit) || force_trig || r_force_pend);

   assign w_prefill_last = (r_state == S_PREFILL) && sample_valid &&
                           (r_count == PREFILL_LAST);
   assign w_post_last    = (r_state == S_POST) && sample_valid &&
                           (r_count == POST_LAST);

   // Index wraps modulo DEPTH through the natural width of the adder.
   assign w_rd_index = r_start_ptr + rd_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:      if (w_arm_ok)       w_next_state = S_PREFILL;
         S_PREFILL:   if (w_prefill_last) w_next_state = S_WAIT_TRIG;
         S_WAIT_TRIG: if (w_trig)         w_next_state = S_POST;
         S_POST:      if (w_post_last)    w_next_state = S_DONE;
         S_DONE:      if (w_arm_ok)       w_next_state = S_PREFILL;
         default:                         w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         S_PREFILL, S_WAIT_TRIG, S_POST: busy = 1'b1;
         S_DONE:                         done = 1'b1;
         default: ;
      endcase
   end

   // Buffer RAM has no reset so it can map onto a block memory.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= sample_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr     <= '0;
         r_start_ptr  <= '0;
         r_count      <= '0;
         r_prev       <= '0;
         r_prev_ok    <= 1'b0;
         r_force_pend <= 1'b0;
         r_rd_data    <= '0;
      end else begin
         r_rd_data <= r_mem[w_rd_index];

         if (w_wr_en) begin
            r_wr_ptr  <= r_wr_ptr + 1'b1;
            r_prev    <= sample_in;
            r_prev_ok <= 1'b1;
         end

         if (w_arm_ok) begin
            // wr_ptr is left alone: the buffer is circular.
            r_count      <= '0;
            r_prev_ok    <= 1'b0;
            r_force_pend <= 1'b0;
         end else begin
            case (r_state)
               S_PREFILL: begin
                  if (sample_valid) r_count <= r_count + 1'b1;
               end
               S_WAIT_TRIG: begin
                  if (w_trig) begin
                     r_count      <= CNT_W'(1);
                     r_start_ptr  <= r_wr_ptr - PRE_OFFSET;
                     r_force_pend <= 1'b0;
                  end else if (force_trig) begin
                     r_force_pend <= 1'b1;
                  end
               end
               S_POST: begin
                  if (sample_valid) r_count <= r_count + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign rd_data = r_rd_data;

endmodule

// File: tb/tb_trigger_capture.sv
module tb_trigger_capture;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] sample_in = '0;
   logic       sample_valid = 1'b0;
   logic       arm = 1'b0;
   logic       force_trig = 1'b0;
   logic [7:0] trig_level = '0;
   logic       trig_slope = 1'b0;
   logic [7:0] rd_addr = '0;
   logic [7:0] rd_data;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_pass   = 0;

   trigger_capture #(.DATA_W(8), .ADDR_W(8), .PRETRIG(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .arm          (arm),
      .force_trig   (force_trig),
      .trig_level   (trig_level),
      .trig_slope   (trig_slope),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // mode 0: ramp mod 256; mode 6: 200 x70, 100 x10, then 150
   function automatic logic [7:0] sval(input int mode, input int k);
      if (mode == 6) begin
         if (k < 70)      return 8'd200;
         else if (k < 80) return 8'd100;
         else             return 8'd150;
      end
      return 8'(k % 256);
   endfunction

   // Arms, then feeds n_valid samples; done must rise exactly after the last.
   task automatic capture(input string name, input int mode, input bit tog,
                          input int n_valid, input int arm_at);
      int k;
      int edges;
      k = 0;
      edges = 0;
      sample_valid = 1'b0;
      arm = 1'b1;
      step();
      arm = 1'b0;
      while (k < n_valid) begin
         if (tog && (edges % 2 == 1)) begin
            sample_valid = 1'b0;
            arm = 1'b0;
         end else begin
            sample_valid = 1'b1;
            sample_in = sval(mode, k);
            arm = (k == arm_at);
            if (k == n_valid - 1) begin
               n_checks++;
               if (done !== 1'b0 || busy !== 1'b1)
                  $display("FAIL %s pre_last: done=%b busy=%b required done=0 busy=1", name, done, busy);
               else n_pass++;
            end
            k++;
         end
         step();
         edges++;
      end
      sample_valid = 1'b0;
      arm = 1'b0;
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0)
         $display("FAIL %s done_rise: done=%b busy=%b required done=1 busy=0", name, done, busy);
      else n_pass++;
   endtask

   task automatic check_rec(input string name, input logic [7:0] addr, input logic [7:0] exp);
      rd_addr = addr;
      step();
      n_checks++;
      if (rd_data !== exp)
         $display("FAIL %s rd[%0d]: got %0d required %0d", name, addr, rd_data, exp);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || rd_data !== 8'd0)
         $display("FAIL reset: busy=%b done=%b rd_data=%0d required 0 0 0", busy, done, rd_data);
      else n_pass++;
      rst = 1'b0;
      step();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL reset_idle: busy=%b done=%b required 0 0", busy, done);
      else n_pass++;
   endtask

   task automatic test_rising_ramp();
      trig_level = 8'd128;
      trig_slope = 1'b0;
      // trigger at sample 128, record ends at sample 128+191 = 319
      capture("rising", 0, 1'b0, 320, -1);
      check_rec("rising", 8'd0,   8'd64);
      check_rec("rising", 8'd64,  8'd128);
      check_rec("rising", 8'd63,  8'd127);
      check_rec("rising", 8'd255, 8'd63);
   endtask

   task automatic test_falling_wrap();
      trig_level = 8'd200;
      trig_slope = 1'b1;
      // trigger on the wrap sample (index 256, value 0)
      capture("falling", 0, 1'b0, 448, -1);
      check_rec("falling", 8'd64,  8'd0);
      check_rec("falling", 8'd63,  8'd255);
      check_rec("falling", 8'd0,   8'd192);
      check_rec("falling", 8'd255, 8'd191);
   endtask

   task automatic test_force();
      trig_level = 8'd128;
      trig_slope = 1'b0;
      sample_valid = 1'b0;
      arm = 1'b1;
      step();
      arm = 1'b0;
      sample_valid = 1'b1;
      sample_in = 8'd50;
      for (int i = 0; i < 300; i++) step();
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0)
         $display("FAIL force_wait: busy=%b done=%b required 1 0", busy, done);
      else n_pass++;
      force_trig = 1'b1;
      step();
      force_trig = 1'b0;
      for (int i = 0; i < 190; i++) step();
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0)
         $display("FAIL force_pre_last: busy=%b done=%b required 1 0", busy, done);
      else n_pass++;
      step();
      sample_valid = 1'b0;
      n_checks++;
      if (done !== 1'b1)
         $display("FAIL force_done: done=%b required 1", done);
      else n_pass++;
      for (int a = 0; a < 256; a += 17) check_rec("force", 8'(a), 8'd50);
      check_rec("force", 8'd255, 8'd50);
   endtask

   task automatic test_valid_toggle();
      trig_level = 8'd128;
      trig_slope = 1'b0;
      capture("toggle", 0, 1'b1, 320, -1);
      check_rec("toggle", 8'd0,   8'd64);
      check_rec("toggle", 8'd64,  8'd128);
      check_rec("toggle", 8'd255, 8'd63);
   endtask

   task automatic test_rst_mid_post();
      trig_level = 8'd128;
      trig_slope = 1'b0;
      sample_valid = 1'b0;
      arm = 1'b1;
      step();
      arm = 1'b0;
      for (int k = 0; k < 150; k++) begin
         sample_valid = 1'b1;
         sample_in = 8'(k);
         step();
      end
      sample_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b1)
         $display("FAIL rst_mid_inpost: busy=%b required 1", busy);
      else n_pass++;
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL rst_mid: busy=%b done=%b required 0 0", busy, done);
      else n_pass++;
      // arm pulse at sample 100 (WAIT_TRIG) must be ignored
      capture("rearm", 0, 1'b0, 320, 100);
      check_rec("rearm", 8'd0,   8'd64);
      check_rec("rearm", 8'd64,  8'd128);
   endtask

   task automatic test_above_at_arm();
      trig_level = 8'd128;
      trig_slope = 1'b0;
      // trigger at index 80 (first 150), record starts at index 16
      capture("above", 6, 1'b0, 272, -1);
      check_rec("above", 8'd0,   8'd200);
      check_rec("above", 8'd53,  8'd200);
      check_rec("above", 8'd54,  8'd100);
      check_rec("above", 8'd63,  8'd100);
      check_rec("above", 8'd64,  8'd150);
      check_rec("above", 8'd255, 8'd150);
   endtask

   initial begin
      test_reset();
      test_rising_ramp();
      test_falling_wrap();
      test_force();
      test_valid_toggle();
      test_rst_mid_post();
      test_above_at_arm();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
